// File: rtl/countdown_timer_pkg.sv
// Shared types for the countdown timer.
// State encoding and prescaler width.
package countdown_timer_pkg;
  localparam int PSC_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10
  } state_t;
endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle of the countdown timer.
// master drives load/start/stop/pause/auto_reload; slave returns count/busy/done.
interface countdown_timer_if #(
  parameter int WIDTH = 15
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic             pause;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load, load_value, start,
    output stop, pause, auto_reload,
    input  count, busy, done
  );

  modport slave (
    input  load, load_value, start,
    input  stop, pause, auto_reload,
    output count, busy, done
  );
endinterface

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler: tick every PRESCALE enabled cycles.
// Ports: clk, reset (async low), enable, clear, tick.
module tick_gen
  import countdown_timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam logic [PSC_W-1:0] LAST =
    PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + PSC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/countdown_timer.sv
// Loadable prescaled down-counter, done pulse at zero.
// Ports: clk, reset (async low), bus (slave: load/start/stop/pause in, count/busy/done out).
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH    = 15,
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  countdown_timer_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             done_q;
  logic             run_en;
  logic             psc_clr;
  logic             tick;

  // Prescaler only advances in cycles where RUN actually counts.
  assign run_en = (state_q == RUN) && !bus.load
               && !bus.stop && !bus.pause;
  assign psc_clr = bus.load
                || ((state_q == IDLE) && bus.start
                    && !bus.stop && (count_q != '0));

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(run_en),
    .clear (psc_clr),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        count_q  <= bus.load_value;
        reload_q <= bus.load_value;
        state_q  <= IDLE;
      end else if (bus.stop) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.start) begin
              if (count_q != '0) state_q <= RUN;
              else               done_q  <= 1'b1;
            end
          end
          RUN: begin
            if (bus.pause) begin
              state_q <= PAUSED;
            end else if (tick) begin
              if (count_q == ONE) begin
                done_q <= 1'b1;
                if (bus.auto_reload && reload_q != '0) begin
                  count_q <= reload_q;
                end else begin
                  count_q <= '0;
                  state_q <= IDLE;
                end
              end else if (count_q != '0) begin
                count_q <= count_q - ONE;
              end
            end
          end
          PAUSED: begin
            if (!bus.pause) state_q <= RUN;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: PRESCALE=1 and PRESCALE=4 timers
// driven in parallel, compared against a run-time model.
module tb_countdown_timer;
  localparam int W = 15;

  logic clk;
  logic reset;
  logic load, start, stop, pause, ar;
  logic [W-1:0] lv;
  int total;
  int passed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  countdown_timer_if #(.WIDTH(W)) b1 ();
  countdown_timer_if #(.WIDTH(W)) b4 ();

  assign b1.load = load;
  assign b1.load_value = lv;
  assign b1.start = start;
  assign b1.stop = stop;
  assign b1.pause = pause;
  assign b1.auto_reload = ar;
  assign b4.load = load;
  assign b4.load_value = lv;
  assign b4.start = start;
  assign b4.stop = stop;
  assign b4.pause = pause;
  assign b4.auto_reload = ar;

  countdown_timer #(.WIDTH(W), .PRESCALE(1)) u1 (
    .clk(clk), .reset(reset), .bus(b1.slave)
  );
  countdown_timer #(.WIDTH(W), .PRESCALE(4)) u4 (
    .clk(clk), .reset(reset), .bus(b4.slave)
  );

  // Model: count = base - (enabled run cycles)/P.
  typedef struct {
    int base;
    int rc;
    int reload;
    int p;
    bit active;
    bit paused;
    bit done;
  } mdl_t;

  mdl_t m1, m4;

  function automatic int mcount(mdl_t m);
    return m.active ? m.base - m.rc / m.p : m.base;
  endfunction

  task automatic mreset(inout mdl_t m);
    m.base = 0; m.rc = 0; m.reload = 0;
    m.active = 0; m.paused = 0; m.done = 0;
  endtask

  task automatic mstep(inout mdl_t m);
    int cur;
    cur = mcount(m);
    m.done = 0;
    if (load) begin
      m.base = int'(lv); m.reload = int'(lv);
      m.active = 0; m.paused = 0; m.rc = 0;
    end else if (stop) begin
      if (m.active) begin
        m.base = cur; m.active = 0;
        m.paused = 0; m.rc = 0;
      end
    end else if (m.active && m.paused) begin
      if (!pause) m.paused = 0;
    end else if (m.active) begin
      if (pause) begin
        m.paused = 1;
      end else begin
        m.rc++;
        if (m.rc == m.base * m.p) begin
          m.done = 1;
          m.rc = 0;
          if (ar && m.reload != 0) begin
            m.base = m.reload;
          end else begin
            m.base = 0;
            m.active = 0;
          end
        end
      end
    end else if (start) begin
      if (m.base != 0) begin
        m.active = 1; m.rc = 0;
      end else begin
        m.done = 1;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h t=%0t",
               tag, obs, exp, $time);
    else
      passed++;
  endtask

  task automatic cmp();
    chk("cnt1", 32'(b1.count), mcount(m1));
    chk("busy1", 32'(b1.busy), 32'(m1.active));
    chk("done1", 32'(b1.done), 32'(m1.done));
    chk("cnt4", 32'(b4.count), mcount(m4));
    chk("busy4", 32'(b4.busy), 32'(m4.active));
    chk("done4", 32'(b4.done), 32'(m4.done));
  endtask

  task automatic cycle();
    @(posedge clk);
    mstep(m1);
    mstep(m4);
    @(negedge clk);
    cmp();
  endtask

  task automatic clr();
    load = 0; start = 0; stop = 0; pause = 0;
  endtask

  task automatic go(int n);
    lv = W'(n); load = 1; cycle(); load = 0;
    start = 1; cycle(); start = 0;
  endtask

  initial begin
    total = 0; passed = 0;
    clr(); ar = 0; lv = '0;
    m1.p = 1; m4.p = 4;
    mreset(m1); mreset(m4);
    reset = 1'b1;
    #2 reset = 1'b0;
    #10;
    cmp();
    @(negedge clk) reset = 1'b1;

    // basic countdown, PRESCALE=1 explicit
    go(3);
    chk("p1_start", 32'(b1.count), 3);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("p1_seq", 32'(b1.count), 32'(2 - i));
    end
    chk("p1_done", 32'(b1.done), 1);
    chk("p1_busy", 32'(b1.busy), 0);
    repeat (10) cycle();

    // prescale 4, explicit timeline
    go(2);
    for (int i = 1; i <= 9; i++) begin
      cycle();
      chk("p4_cnt", 32'(b4.count),
          (i < 4) ? 2 : ((i < 8) ? 1 : 0));
      chk("p4_done", 32'(b4.done), 32'(i == 8));
    end

    // auto-reload
    ar = 1;
    go(2);
    repeat (20) cycle();
    chk("ar_busy", 32'(b1.busy), 1);
    ar = 0;
    repeat (10) cycle();

    // pause / stop / restart
    go(5);
    cycle();
    chk("pre_pause", 32'(b1.count), 4);
    pause = 1;
    repeat (3) cycle();
    chk("pause_hold", 32'(b1.count), 4);
    pause = 0;
    cycle();
    cycle();
    chk("resume", 32'(b1.count), 3);
    cycle();
    stop = 1; cycle(); stop = 0;
    chk("stop_hold", 32'(b1.count), 2);
    chk("stop_busy", 32'(b1.busy), 0);
    start = 1; cycle(); start = 0;
    cycle();
    chk("restart", 32'(b1.count), 1);
    repeat (30) cycle();

    // load on terminal tick
    go(2);
    cycle();
    lv = W'(7); load = 1; cycle(); load = 0;
    chk("coll_cnt", 32'(b1.count), 7);
    chk("coll_done", 32'(b1.done), 0);

    // start with count 0
    lv = '0; load = 1; cycle(); load = 0;
    start = 1; cycle(); start = 0;
    chk("zero_done", 32'(b1.done), 1);
    chk("zero_busy", 32'(b1.busy), 0);
    cycle();

    // async reset mid-run
    go(5);
    cycle();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    mreset(m1); mreset(m4);
    chk("rst_cnt1", 32'(b1.count), 0);
    chk("rst_busy1", 32'(b1.busy), 0);
    chk("rst_done1", 32'(b1.done), 0);
    chk("rst_cnt4", 32'(b4.count), 0);
    chk("rst_busy4", 32'(b4.busy), 0);
    @(negedge clk);
    cmp();
    reset = 1'b1;
    repeat (8) cycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(0, 99) < 4);
      lv = W'($urandom_range(0, 9));
      start = ($urandom_range(0, 99) < 15);
      stop = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 10) pause = ~pause;
      if ($urandom_range(0, 99) < 5) ar = ~ar;
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
